divider_arbiter_2ch: RTL and testbench
======================================

# divider_arbiter_2ch

Sequential restoring divider shared between two requesters under round-robin arbitration. Each requester presents an unsigned dividend/divisor pair on a valid/ready handshake. The block computes one quotient bit per cycle and returns quotient, remainder, requester ID and a divide-by-zero flag on a single response channel with valid/ready backpressure. It replaces per-requester instances of the combinational 4-bit divider wherever area matters more than latency.

## Interface
- WIDTH, 4: operand/result width in bits (unsigned), ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  channel 0 request valid
- req0_ready  out  1  channel 0 request accepted this cycle when high with req0_valid
- req0_dividend  in  WIDTH  channel 0 dividend
- req0_divisor  in  WIDTH  channel 0 divisor
- req1_valid / req1_ready / req1_dividend / req1_divisor: channel 1, same as channel 0
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  channel that issued the result
- rsp_quotient  out  WIDTH  quotient
- rsp_remainder  out  WIDTH  remainder
- rsp_div_by_zero  out  1  divisor was 0
- busy  out  1  high in BUSY or DONE

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: grant computed combinationally. Only one valid → grant it. Both valid → grant the channel other than last_id. req_ready[grant]=1, all other readies 0. Readies are 0 in BUSY/DONE.
- Accept (valid&&ready in IDLE): capture dividend into Q, divisor into D, channel into id. Clear R (WIDTH+1 bits) and step counter. Set dz = (divisor==0). last_id ← granted channel. Next state BUSY.
- BUSY step, once per cycle: R ← {R[WIDTH-1:0], Q[WIDTH-1]}, Q ← Q<<1. If R ≥ {0,D}, then R ← R−D and Q[0] ← 1. After WIDTH steps, next state DONE.
- Divisor 0 falls out of the algorithm with no special case: quotient = all ones, remainder = dividend, rsp_div_by_zero=1.
- DONE: rsp_valid=1. rsp_quotient=Q, rsp_remainder=R[WIDTH-1:0], rsp_id=id, rsp_div_by_zero=dz. These hold stable until rsp_ready. On rsp_valid&&rsp_ready, next state IDLE.
- Requester operands may change after acceptance without effect. Requests are never dropped: a valid waits until granted.

## Timing
- Reset values: req0_ready=req1_ready=0 during reset (asserted only once rst_n high and in IDLE); rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div_by_zero=0, busy=0. last_id=1, so channel 0 wins the first contention.
- Latency: handshake in cycle T; BUSY during cycles T+1…T+WIDTH; rsp_valid high from cycle T+WIDTH+1.
- Throughput, with rsp_ready held high: one result per WIDTH+2 cycles. The IDLE cycle is mandatory; there is no accept in DONE.
- rsp_ready low: the block stays in DONE indefinitely with outputs frozen.
- rsp_ready may be high before rsp_valid; it has no effect outside DONE.
- Simultaneous valids on consecutive operations alternate strictly 0,1,0,1…
- rst_n asserted mid-BUSY or mid-DONE: immediate return to IDLE, all outputs to reset values, in-flight result discarded. No response is produced for it.
- Ready depends combinationally on valid. Valid must not depend on ready.

## Test plan
- Ch0 8/2, rsp_ready=1 → rsp_valid exactly 5 cycles after the handshake; q=4, r=0, id=0, dz=0. Back in IDLE the next cycle.
- Ch1 15/4 then ch1 7/3 → q=3 r=3, then q=2 r=1, both id=1. Second handshake no earlier than 6 cycles after the first.
- Ch0 9/0 → q=15, r=9, dz=1.
- Both channels held valid (ch0 15/1, ch1 6/4) for 4 operations → ids 0,1,0,1; results q=15 r=0 and q=1 r=2.
- Ch0 13/5 with rsp_ready=0 for 10 cycles → rsp_valid and q=2, r=3 stable throughout; readies 0. Accepted on rsp_ready=1.
- rst_n low 2 cycles into BUSY of ch1 11/3 → outputs 0 during reset, no response emitted. Afterwards ch0 wins contention first.

Source files
------------

// File: rtl/divider_arbiter_2ch.sv
// rtl/divider_arbiter_2ch.sv - two-channel round-robin shared restoring divider
module divider_arbiter_2ch #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_dividend,
   input  logic [WIDTH-1:0] req0_divisor,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_dividend,
   input  logic [WIDTH-1:0] req1_divisor,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_quotient,
   output logic [WIDTH-1:0] rsp_remainder,
   output logic             rsp_div_by_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             id_q, id_d;
   logic             dz_q, dz_d;
   logic             last_id_q, last_id_d;

   logic             grant;
   logic             accept;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH-1:0] q_shift;

   // Round-robin grant: on contention the channel not served last wins
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_id_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Readies are held low while reset is asserted, even though the state is already IDLE
   assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
   assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // One restoring step: shift the next dividend bit into R, subtract D when it fits
   always_comb begin
      r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      q_shift = {q_q[WIDTH-2:0], 1'b0};
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      d_d       = d_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      dz_d      = dz_q;
      last_id_d = last_id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               q_d       = grant ? req1_dividend : req0_dividend;
               d_d       = grant ? req1_divisor  : req0_divisor;
               r_d       = '0;
               cnt_d     = '0;
               id_d      = grant;
               dz_d      = grant ? (req1_divisor == '0) : (req0_divisor == '0);
               last_id_d = grant;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (r_shift >= {1'b0, d_q}) begin
               r_d = r_shift - {1'b0, d_q};
               q_d = q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
               r_d = r_shift;
               q_d = q_shift;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; last_id resets to 1 so channel 0 wins first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         q_q       <= '0;
         d_q       <= '0;
         r_q       <= '0;
         cnt_q     <= '0;
         id_q      <= 1'b0;
         dz_q      <= 1'b0;
         last_id_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         d_q       <= d_d;
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         dz_q      <= dz_d;
         last_id_q <= last_id_d;
      end
   end

   // Response fields are only exposed in DONE so they read zero everywhere else
   always_comb begin
      rsp_valid       = (state_q == DONE);
      busy            = (state_q != IDLE);
      rsp_id          = rsp_valid ? id_q : 1'b0;
      rsp_quotient    = rsp_valid ? q_q : '0;
      rsp_remainder   = rsp_valid ? r_q[WIDTH-1:0] : '0;
      rsp_div_by_zero = rsp_valid ? dz_q : 1'b0;
   end

endmodule

// File: tb/tb_divider_arbiter_2ch.sv
// tb/tb_divider_arbiter_2ch.sv - randomized scoreboard bench for divider_arbiter_2ch
module tb_divider_arbiter_2ch;

   localparam int W      = 4;
   localparam int NDIR   = 5;
   localparam int NCYCLE = 4000;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready;
   logic [W-1:0] req0_dividend, req0_divisor;
   logic         req1_valid, req1_ready;
   logic [W-1:0] req1_dividend, req1_divisor;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_quotient, rsp_remainder;
   logic         rsp_div_by_zero, busy;

   divider_arbiter_2ch #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_dividend   (req0_dividend),
      .req0_divisor    (req0_divisor),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_dividend   (req1_dividend),
      .req1_divisor    (req1_divisor),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_quotient    (rsp_quotient),
      .rsp_remainder   (rsp_remainder),
      .rsp_div_by_zero (rsp_div_by_zero),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pending request per channel, held until the model sees it accepted
   logic         v [2];
   logic [W-1:0] dvd [2];
   logic [W-1:0] dvs [2];
   logic [W-1:0] dir_dvd [2][NDIR];
   logic [W-1:0] dir_dvs [2][NDIR];
   int           dir_idx [2];

   // Reference model state
   logic         in_flight;
   int           exp_rsp_cyc;
   logic         exp_last;
   logic         exp_id;
   logic [W-1:0] exp_q, exp_r;
   logic         exp_dz;
   logic         g;
   int           rst_hold;
   int           stall_left;

   initial begin
      dir_dvd[0][0] = 4'd8;  dir_dvs[0][0] = 4'd2;
      dir_dvd[0][1] = 4'd9;  dir_dvs[0][1] = 4'd0;
      dir_dvd[0][2] = 4'd13; dir_dvs[0][2] = 4'd5;
      dir_dvd[0][3] = 4'd15; dir_dvs[0][3] = 4'd1;
      dir_dvd[0][4] = 4'd15; dir_dvs[0][4] = 4'd1;
      dir_dvd[1][0] = 4'd15; dir_dvs[1][0] = 4'd4;
      dir_dvd[1][1] = 4'd7;  dir_dvs[1][1] = 4'd3;
      dir_dvd[1][2] = 4'd6;  dir_dvs[1][2] = 4'd4;
      dir_dvd[1][3] = 4'd6;  dir_dvs[1][3] = 4'd4;
      dir_dvd[1][4] = 4'd11; dir_dvs[1][4] = 4'd3;
      dir_idx[0] = 0;
      dir_idx[1] = 0;
      v[0] = 1'b0;  v[1] = 1'b0;
      dvd[0] = '0;  dvd[1] = '0;
      dvs[0] = '0;  dvs[1] = '0;
      in_flight   = 1'b0;
      exp_rsp_cyc = 0;
      exp_last    = 1'b1;
      exp_id      = 1'b0;
      exp_q       = '0;
      exp_r       = '0;
      exp_dz      = 1'b0;
      rst_hold    = 3;
      stall_left  = 0;

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_dividend = '0; req0_divisor = '0;
      req1_valid = 1'b0; req1_dividend = '0; req1_divisor = '0;
      rsp_ready = 1'b0;

      for (int cyc = 0; cyc < NCYCLE; cyc++) begin
         @(negedge clk);

         // Occasional reset pulse of two cycles while an operation is in flight
         if (rst_hold == 0 && in_flight && $urandom_range(0, 149) == 0) rst_hold = 2;
         rst_n = (rst_hold == 0);
         if (rst_hold > 0) rst_hold--;

         // Raise new requests: directed operands first, then random ones
         for (int ch = 0; ch < 2; ch++) begin
            if (!v[ch] && (dir_idx[ch] < NDIR || $urandom_range(0, 2) == 0)) begin
               v[ch] = 1'b1;
               if (dir_idx[ch] < NDIR) begin
                  dvd[ch] = dir_dvd[ch][dir_idx[ch]];
                  dvs[ch] = dir_dvs[ch][dir_idx[ch]];
                  dir_idx[ch]++;
               end else begin
                  dvd[ch] = W'($urandom);
                  dvs[ch] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
               end
            end
         end

         // Consumer backpressure: mostly ready, with occasional long stalls
         if (stall_left == 0 && $urandom_range(0, 19) == 0) stall_left = $urandom_range(1, 12);
         rsp_ready = (stall_left == 0) ? ($urandom_range(0, 5) != 0) : 1'b0;
         if (stall_left > 0) stall_left--;

         req0_valid = v[0]; req0_dividend = dvd[0]; req0_divisor = dvs[0];
         req1_valid = v[1]; req1_dividend = dvd[1]; req1_divisor = dvs[1];

         #1;
         if (!rst_n) begin
            check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
            check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
            check_eq("rst_rsp_valid",  32'(rsp_valid), 32'd0);
            check_eq("rst_rsp_id",     32'(rsp_id), 32'd0);
            check_eq("rst_quotient",   32'(rsp_quotient), 32'd0);
            check_eq("rst_remainder",  32'(rsp_remainder), 32'd0);
            check_eq("rst_dz",         32'(rsp_div_by_zero), 32'd0);
            check_eq("rst_busy",       32'(busy), 32'd0);
            in_flight = 1'b0;
            exp_last  = 1'b1;
         end else if (!in_flight) begin
            if (v[0] && v[1]) g = ~exp_last;
            else              g = v[1];
            check_eq("idle_req0_ready", 32'(req0_ready), 32'(v[0] && !g));
            check_eq("idle_req1_ready", 32'(req1_ready), 32'(v[1] && g));
            check_eq("idle_rsp_valid",  32'(rsp_valid), 32'd0);
            check_eq("idle_busy",       32'(busy), 32'd0);
            if (v[0] || v[1]) begin
               in_flight   = 1'b1;
               exp_rsp_cyc = cyc + W + 1;
               exp_id      = g;
               exp_last    = g;
               exp_dz      = (dvs[g] == '0);
               exp_q       = exp_dz ? {W{1'b1}} : dvd[g] / dvs[g];
               exp_r       = exp_dz ? dvd[g] : dvd[g] % dvs[g];
               v[g]        = 1'b0;
            end
         end else if (cyc < exp_rsp_cyc) begin
            check_eq("busy_rsp_valid",  32'(rsp_valid), 32'd0);
            check_eq("busy_busy",       32'(busy), 32'd1);
            check_eq("busy_req0_ready", 32'(req0_ready), 32'd0);
            check_eq("busy_req1_ready", 32'(req1_ready), 32'd0);
         end else begin
            check_eq("done_rsp_valid",  32'(rsp_valid), 32'd1);
            check_eq("done_busy",       32'(busy), 32'd1);
            check_eq("done_req0_ready", 32'(req0_ready), 32'd0);
            check_eq("done_req1_ready", 32'(req1_ready), 32'd0);
            check_eq("done_rsp_id",     32'(rsp_id), 32'(exp_id));
            check_eq("done_quotient",   32'(rsp_quotient), 32'(exp_q));
            check_eq("done_remainder",  32'(rsp_remainder), 32'(exp_r));
            check_eq("done_dz",         32'(rsp_div_by_zero), 32'(exp_dz));
            if (rsp_ready) in_flight = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
